mem_write_buffer: RTL
=====================

# mem_write_buffer

Store write buffer between the MEM stage and the AXI write-channel adapter. Accepts store requests (address, data, byte select) into a small FIFO so the pipeline does not stall on every store. Drains one entry at a time to the adapter's `we`/`address`/`data`/`select` port and retires it on `mem_write_done`. Guarantees a `we`-low gap between transactions so the adapter's per-transaction valid-done flags clear.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `PTR_W`, 2: log2(`DEPTH`).
- `clk` in 1: single clock, all state on the rising edge.
- `reset` in 1: synchronous, active-high; `reset == 1'b1` at a rising edge clears all state.
- `push_valid` in 1: store request from the MEM stage.
- `push_addr` in 32: store address, virtual; passed through unmodified.
- `push_data` in 32: store data.
- `push_select` in 4: byte strobes.
- `push_ready` out 1: buffer not full; a push is accepted only when `push_valid && push_ready`.
- `wb_we` out 1: write request to the adapter (`we`).
- `wb_address` out 32: head entry address.
- `wb_data` out 32: head entry data.
- `wb_select` out 4: head entry strobes.
- `wb_done` in 1: adapter `mem_write_done` (B-channel response pulse).
- `count` out PTR_W+1: valid entries, 0..DEPTH.
- `empty` out 1: `count == 0` and state is IDLE; used by the pipeline to fence (e.g. before uncached loads).
- `query_addr` in 32: load address for the hazard check.
- `query_hit` out 1: a pending store overlaps `query_addr`.

## Operation
- Storage: circular FIFO with `wr_ptr`, `rd_ptr` (PTR_W bits, wrap modulo DEPTH) and `count`. Entry payload is addr/data/select. Entries are not cleared on reset.
- Push: on an accepted push, write the entry at `wr_ptr`, increment `wr_ptr`, and increment `count`.
- Pop: occurs only in DRAIN when `wb_done == 1`. Increment `rd_ptr` and decrement `count`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- `push_ready = (count != DEPTH)`. Because this is registered-count based, a pop in the same cycle does not admit a push when full.
- Drain FSM, 3 states:
  - IDLE: `wb_we = 0`. Go to DRAIN if `count != 0`.
  - DRAIN: `wb_we = 1`, head entry presented. Stay in DRAIN until `wb_done`, then go to GAP with a pop.
  - GAP: `wb_we = 0` for exactly one cycle. Go to DRAIN if `count != 0` (post-pop value), else go to IDLE.
- `wb_done` is ignored in IDLE and GAP; a stray pulse has no effect.
- Head fields remain stable throughout DRAIN; a push never modifies the head entry.
- `wb_address`, `wb_data` and `wb_select` equal the head entry when `wb_we = 1`, and are all-zero otherwise.
- Reset mid-transaction: the buffer empties and the FSM goes to IDLE. Any later response for the abandoned write is ignored.

## Timing
- Reset values: `wb_we` 0, `wb_address`/`wb_data`/`wb_select` 0, `count` 0, `push_ready` 1, `empty` 1, `query_hit` 0.
- Push-to-request latency: a push accepted at edge N into an IDLE buffer gives `wb_we = 1` in the cycle after edge N+1.
- `wb_done` high in DRAIN at edge M: `wb_we = 0` in the cycle after M (GAP). If more entries remain, `wb_we = 1` again in the cycle after M+1.
- Steady-state throughput: one store per (adapter latency + 1 GAP cycle).
- `push_ready`, `empty`, `count` and the data outputs are derived from registers only. `query_hit` is combinational from `query_addr`.

## Configuration
- `WB_HAZARD_CHECK_EN` defined:
  - `query_hit = 1` when any valid entry, including the in-flight head, has `addr[31:2] == query_addr[31:2]`.
  - The comparison is combinational over all DEPTH entries, qualified by per-entry occupancy derived from `rd_ptr`/`count`.
- Not defined: `query_hit` is tied to 0 and `query_addr` is unused. The pipeline must then fence with `empty`.

## Test plan
- Reset behaviour: hold `reset` for 2 cycles with `push_valid` = 1 -> `count` = 0, `wb_we` = 0, `push_ready` = 1, and no entry is captured.
- Single store: push addr 0x8000_0010, data 0xDEADBEEF, select 0xF; `wb_done` pulses 3 cycles after `wb_we` rises. Required response:
  - `wb_we` rises 1 cycle after the accept, with head fields exact.
  - One GAP cycle, then IDLE with `empty` = 1.
- Back-to-back drain: push 4 stores on consecutive cycles with DEPTH = 4. Required response:
  - `push_ready` = 0 after the 4th push; a 5th push is ignored.
  - Entries drain in order, with `wb_we` low exactly 1 cycle between each.
- Wrap-around with simultaneous push/pop: keep count at 3 while cycling 10 stores -> `count` is stable across push+pop edges, pointers wrap, and data order is preserved.
- Reset mid-DRAIN: assert `reset` while `wb_we` = 1, then pulse `wb_done` in the cycle after reset releases -> buffer stays empty and no pop underflow occurs (`count` = 0).
- Hazard check (`WB_HAZARD_CHECK_EN` defined): pending store at 0x1000_0004; `query_addr` 0x1000_0006 -> `query_hit` = 1; 0x1000_0008 -> 0. After `wb_done` retires the entry -> 0. With the macro undefined, `query_hit` = 0 always.

Source files
------------

// File: rtl/mem_write_buffer_if.sv
// Store request / write-port bundle between the MEM stage, the write buffer and the AXI write adapter.
// The slave view belongs to the buffer; the master view belongs to the surrounding pipeline/adapter.
interface mem_write_buffer_if;
    logic        push_valid;
    logic [31:0] push_addr;
    logic [31:0] push_data;
    logic [3:0]  push_select;
    logic        push_ready;
    logic        wb_we;
    logic [31:0] wb_address;
    logic [31:0] wb_data;
    logic [3:0]  wb_select;
    logic        wb_done;

    modport master (
        output push_valid, push_addr, push_data, push_select,
        input  push_ready,
        input  wb_we, wb_address, wb_data, wb_select,
        output wb_done
    );

    modport slave (
        input  push_valid, push_addr, push_data, push_select,
        output push_ready,
        output wb_we, wb_address, wb_data, wb_select,
        input  wb_done
    );
endinterface

// File: rtl/mem_write_buffer.sv
// Store write buffer: small circular FIFO drained one entry at a time, with a one-cycle we-low gap.
// Optional macro WB_HAZARD_CHECK_EN enables the load/store address overlap check on query_addr.
module mem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_write_buffer_if.slave  bus,
    output logic [PTR_W:0]     count,
    output logic               empty,
    input  logic [31:0]        query_addr,
    output logic               query_hit
);
    typedef enum logic [1:0] {IDLE, DRAIN, GAP} state_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [31:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [3:0]  sel_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    state_t           state_reg;
    state_t           state_next;
    logic             push_fire;
    logic             pop_fire;
    logic             drain_we;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign push_fire = bus.push_valid && (count_reg != FULL_COUNT);
    assign pop_fire  = (state_reg == DRAIN) && bus.wb_done;

    always_ff @(posedge clk) begin
        if (push_fire) begin
            addr_mem[wr_ptr_reg] <= bus.push_addr;
            data_mem[wr_ptr_reg] <= bus.push_data;
            sel_mem[wr_ptr_reg]  <= bus.push_select;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= IDLE;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            state_reg <= state_next;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push_fire, pop_fire})
            2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
            2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // GAP holds we low for one cycle so the adapter's per-transaction flags can clear.
    always_comb begin
        state_next = state_reg;
        drain_we   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                drain_we = 1'b1;
                if (bus.wb_done) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = (count_reg != '0) ? DRAIN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.wb_we      = drain_we;
    assign bus.wb_address = drain_we ? addr_mem[rd_ptr_reg] : 32'h0;
    assign bus.wb_data    = drain_we ? data_mem[rd_ptr_reg] : 32'h0;
    assign bus.wb_select  = drain_we ? sel_mem[rd_ptr_reg]  : 4'h0;
    assign bus.push_ready = (count_reg != FULL_COUNT);

    assign count = count_reg;
    assign empty = (count_reg == '0) && (state_reg == IDLE);

`ifdef WB_HAZARD_CHECK_EN
    logic [DEPTH-1:0] hit_vec;
    logic             unused_query_lsb;

    // An entry is occupied when its distance from the head is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [PTR_W-1:0] offset;
        assign offset      = PTR_W'(gi) - rd_ptr_reg;
        assign hit_vec[gi] = ({1'b0, offset} < count_reg) &&
                             (addr_mem[gi][31:2] == query_addr[31:2]);
    end

    assign query_hit        = |hit_vec;
    assign unused_query_lsb = ^query_addr[1:0];
`else
    logic unused_query;
    assign unused_query = ^query_addr;
    assign query_hit    = 1'b0;
`endif

endmodule
